// File: rtl/sine_taylor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sine_taylor_pkg
// Description : Shared definitions for the sine_taylor arbiter slice: FSM
//               state encoding, default widths and the round-robin select
//               helper used by rr_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package sine_taylor_pkg;

    localparam int C_DEF_DWIDTH = 16;   // default sample width
    localparam int C_MAX_CH     = 16;   // largest supported channel count
    localparam int C_SEL_W      = 4;    // index width covering C_MAX_CH

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_ISSUE   = 2'd1;
    localparam state_t ST_WAIT    = 2'd2;
    localparam state_t ST_DELIVER = 2'd3;

    // Returns the first set bit of valid scanning upward from ptr+1 with
    // wrap at num_ch. Returns 0 when nothing is set; callers qualify the
    // result with an any-valid flag.
    function automatic logic [C_SEL_W-1:0] rr_select(
        input logic [C_MAX_CH-1:0] valid,
        input logic [C_SEL_W-1:0]  ptr,
        input int                  num_ch
    );
        logic [C_SEL_W-1:0] idx;
        logic               found;
        rr_select = '0;
        found     = 1'b0;
        for (int k = 1; k <= C_MAX_CH; k++) begin
            if (!found && (k <= num_ch)) begin
                idx = C_SEL_W'((int'(ptr) + k) % num_ch);
                if (valid[idx]) begin
                    rr_select = idx;
                    found     = 1'b1;
                end
            end
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/sine_taylor_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin select with a registered priority
//               pointer. The pointer moves to the finished grant's index when
//               i_grant_done pulses, so that channel becomes lowest priority.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               i_valid           - per-channel request vector
//               i_grant_done      - current grant completed this cycle
//               i_grant_idx       - index of the completed grant
//               o_sel / o_any     - winning index / any request pending
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import sine_taylor_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] i_valid,
    input  logic              i_grant_done,
    input  logic [SEL_W-1:0]  i_grant_idx,
    output logic [SEL_W-1:0]  o_sel,
    output logic              o_any
);

    logic [SEL_W-1:0]    r_ptr;
    logic [C_MAX_CH-1:0] w_valid_ext;
    logic [C_SEL_W-1:0]  w_ptr_ext;
    logic [C_SEL_W-1:0]  w_sel_ext;
    logic                w_unused_sel;

    // Widen to the package helper's fixed width so one function serves
    // every channel count.
    always_comb begin
        w_valid_ext                = '0;
        w_valid_ext[NUM_CH-1:0]    = i_valid;
        w_ptr_ext                  = '0;
        w_ptr_ext[SEL_W-1:0]       = r_ptr;
        w_sel_ext                  = rr_select(w_valid_ext, w_ptr_ext, NUM_CH);
    end

    assign o_sel        = w_sel_ext[SEL_W-1:0];
    assign o_any        = |i_valid;
    assign w_unused_sel = ^w_sel_ext;

    // Reset to the last channel so channel 0 wins the first arbitration.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= SEL_W'(NUM_CH - 1);
        end else if (i_grant_done) begin
            r_ptr <= i_grant_idx;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sine_taylor_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sine_taylor_arbiter
// Description : Shares one sine_taylor core among G_NUM_CH valid/ready
//               requesters. One transaction is in flight at a time:
//               IDLE (arbitrate) -> ISSUE (hand sample to core) ->
//               WAIT (collect result) -> DELIVER (return to requester).
// Ports       : clk, reset, enable       - clock, sync reset, enable (0 = reset)
//               req_data/valid/ready     - packed request streams
//               resp_data/valid/ready    - packed response streams
//               core_din*/core_dout*     - shared core handshake
//               busy, grant_ch           - status: in flight, granted tag
// Revision    : 1.0 - initial release
// ============================================================================
module sine_taylor_arbiter
    import sine_taylor_pkg::*;
#(
    parameter int G_DWIDTH = C_DEF_DWIDTH,
    parameter int G_NUM_CH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [G_NUM_CH*G_DWIDTH-1:0] req_data,
    input  logic [G_NUM_CH-1:0]          req_valid,
    output logic [G_NUM_CH-1:0]          req_ready,
    output logic [G_NUM_CH*G_DWIDTH-1:0] resp_data,
    output logic [G_NUM_CH-1:0]          resp_valid,
    input  logic [G_NUM_CH-1:0]          resp_ready,
    output logic [G_DWIDTH-1:0]          core_din,
    output logic                         core_din_valid,
    input  logic                         core_din_ready,
    input  logic [G_DWIDTH-1:0]          core_dout,
    input  logic                         core_dout_valid,
    output logic                         core_dout_ready,
    output logic                         busy,
    output logic [$clog2(G_NUM_CH)-1:0]  grant_ch
);

    localparam int C_TAG_W = $clog2(G_NUM_CH);

    state_t                        r_state;
    logic [G_DWIDTH-1:0]           r_core_din;
    logic                          r_core_din_valid;
    logic                          r_core_dout_ready;
    logic [G_NUM_CH*G_DWIDTH-1:0]  r_resp_data;
    logic [G_NUM_CH-1:0]           r_resp_valid;
    logic [C_TAG_W-1:0]            r_grant_ch;

    logic                          w_rst;
    logic [C_TAG_W-1:0]            w_sel;
    logic                          w_any;
    logic [G_NUM_CH-1:0]           w_sel_onehot;
    logic [G_NUM_CH-1:0]           w_grant_onehot;
    logic [G_NUM_CH-1:0]           w_req_ready;
    logic [G_NUM_CH*G_DWIDTH-1:0]  w_resp_next;
    logic                          w_accept;
    logic                          w_issue_done;
    logic                          w_core_done;
    logic                          w_deliver_done;

    // Dropping enable is indistinguishable from holding reset.
    assign w_rst = reset | ~enable;

    rr_arbiter #(
        .NUM_CH (G_NUM_CH),
        .SEL_W  (C_TAG_W)
    ) u_rr_arbiter (
        .clk          (clk),
        .rst          (w_rst),
        .i_valid      (req_valid),
        .i_grant_done (w_deliver_done),
        .i_grant_idx  (r_grant_ch),
        .o_sel        (w_sel),
        .o_any        (w_any)
    );

    always_comb begin
        w_sel_onehot          = '0;
        w_sel_onehot[w_sel]   = 1'b1;
        w_grant_onehot        = '0;
        w_grant_onehot[r_grant_ch] = 1'b1;
        // Only the granted slice carries the result; the rest read as zero.
        w_resp_next           = '0;
        w_resp_next[r_grant_ch*G_DWIDTH +: G_DWIDTH] = core_dout;
        // Gated by w_rst so no handshake can complete while held in reset.
        w_req_ready = (r_state == ST_IDLE && w_any && !w_rst) ? w_sel_onehot : '0;
    end

    assign w_accept       = |(req_valid & w_req_ready);
    assign w_issue_done   = (r_state == ST_ISSUE) && r_core_din_valid && core_din_ready;
    assign w_core_done    = (r_state == ST_WAIT) && core_dout_valid && r_core_dout_ready;
    assign w_deliver_done = (r_state == ST_DELIVER) &&
                            (|(resp_ready & r_resp_valid & w_grant_onehot));

    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_state           <= ST_IDLE;
            r_core_din        <= '0;
            r_core_din_valid  <= 1'b0;
            r_core_dout_ready <= 1'b0;
            r_resp_data       <= '0;
            r_resp_valid      <= '0;
            r_grant_ch        <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_core_din       <= req_data[w_sel*G_DWIDTH +: G_DWIDTH];
                        r_grant_ch       <= w_sel;
                        r_core_din_valid <= 1'b1;
                        r_state          <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (w_issue_done) begin
                        r_core_din_valid  <= 1'b0;
                        r_core_dout_ready <= 1'b1;
                        r_state           <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (w_core_done) begin
                        r_resp_data       <= w_resp_next;
                        r_core_dout_ready <= 1'b0;
                        r_resp_valid      <= w_grant_onehot;
                        r_state           <= ST_DELIVER;
                    end
                end
                ST_DELIVER: begin
                    if (w_deliver_done) begin
                        r_resp_valid <= '0;
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready       = w_req_ready;
    assign resp_data       = r_resp_data;
    assign resp_valid      = r_resp_valid;
    assign core_din        = r_core_din;
    assign core_din_valid  = r_core_din_valid;
    assign core_dout_ready = r_core_dout_ready;
    assign busy            = (r_state != ST_IDLE);
    assign grant_ch        = r_grant_ch;

endmodule
`default_nettype wire

// File: tb/tb_sine_taylor_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sine_taylor_arbiter
// Description : Self-checking bench for sine_taylor_arbiter (4 ch x 16 bit).
//               The core model answers ~din five cycles after accepting.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sine_taylor_arbiter;

    localparam int DW  = 16;
    localparam int NCH = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic [NCH*DW-1:0] req_data;
    logic [NCH-1:0]    req_valid;
    logic [NCH-1:0]    req_ready;
    logic [NCH*DW-1:0] resp_data;
    logic [NCH-1:0]    resp_valid;
    logic [NCH-1:0]    resp_ready;
    logic [DW-1:0]     core_din;
    logic              core_din_valid;
    logic              core_din_ready;
    logic [DW-1:0]     core_dout;
    logic              core_dout_valid;
    logic              core_dout_ready;
    logic              busy;
    logic [1:0]        grant_ch;

    always #5 clk = ~clk;

    sine_taylor_arbiter #(.G_DWIDTH(DW), .G_NUM_CH(NCH)) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .req_data        (req_data),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .resp_data       (resp_data),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .core_din        (core_din),
        .core_din_valid  (core_din_valid),
        .core_din_ready  (core_din_ready),
        .core_dout       (core_dout),
        .core_dout_valid (core_dout_valid),
        .core_dout_ready (core_dout_ready),
        .busy            (busy),
        .grant_ch        (grant_ch)
    );

    // ---------------- core model: result = ~din, 5 cycles after accept ----
    logic          core_rdy_ctl = 1'b1;
    logic          force_dv     = 1'b0;
    logic [DW-1:0] force_d      = '0;
    logic          m_busy;
    logic          m_dv;
    int            m_cnt;
    logic [DW-1:0] m_res;

    assign core_din_ready  = core_rdy_ctl & ~m_busy;
    assign core_dout_valid = m_dv | force_dv;
    assign core_dout       = force_dv ? force_d : m_res;

    always @(posedge clk) begin
        if (reset || !enable) begin
            m_busy <= 1'b0;
            m_dv   <= 1'b0;
            m_cnt  <= 0;
            m_res  <= '0;
        end else if (!m_busy && core_din_valid && core_din_ready) begin
            m_busy <= 1'b1;
            m_cnt  <= 5;
            m_res  <= ~core_din;
        end else if (m_busy && !m_dv) begin
            if (m_cnt == 1) m_dv <= 1'b1;
            m_cnt <= m_cnt - 1;
        end else if (m_dv && core_dout_ready) begin
            m_dv   <= 1'b0;
            m_busy <= 1'b0;
        end
    end

    // ---------------- bookkeeping -----------------------------------------
    int n_checks = 0;
    int n_pass   = 0;
    int grants[$];

    typedef struct {
        int            ch;
        logic [DW-1:0] din;
        logic [DW-1:0] exp;
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic int enc(input logic [NCH-1:0] v);
        int r;
        r = -1;
        for (int i = NCH - 1; i >= 0; i--) if (v[i]) r = i;
        return r;
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        reset     = 1'b1;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1 reset  = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy && t < 60) begin @(negedge clk); t++; end
        check("idle_timeout", 64'(busy), 64'd0);
    endtask

    task automatic wait_resp();
        int t;
        t = 0;
        while (resp_valid == 0 && t < 60) begin @(negedge clk); t++; end
    endtask

    // One isolated transaction with cycle-accurate latency checking.
    task automatic do_single(input int ch, input logic [DW-1:0] d, input logic [DW-1:0] exp);
        logic [NCH-1:0] oh;
        logic [63:0]    mask;
        int             t;
        oh   = NCH'(1) << ch;
        mask = 64'hFFFF << (ch * DW);
        @(posedge clk); #1;
        req_data            = '0;
        req_data[ch*DW +: DW] = d;
        req_valid           = oh;
        t = 0;
        @(negedge clk);
        while (!req_ready[ch] && t < 20) begin @(negedge clk); t++; end
        check("single_req_ready", 64'(req_ready), 64'(oh));
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        check("single_core_din", 64'(core_din), 64'(d));
        check("single_core_din_valid", 64'(core_din_valid), 64'd1);
        check("single_grant_ch", 64'(grant_ch), 64'(ch));
        check("single_busy", 64'(busy), 64'd1);
        t = 0;
        while (resp_valid == 0 && t < 40) begin @(negedge clk); t++; end
        check("single_latency", 64'(t), 64'd7);
        check("single_resp_valid", 64'(resp_valid), 64'(oh));
        check("single_resp_slice", 64'(resp_data[ch*DW +: DW]), 64'(exp));
        check("single_other_slices", resp_data & ~mask, 64'd0);
        @(negedge clk);
        check("single_resp_cleared", 64'(resp_valid), 64'd0);
        check("single_idle", 64'(busy), 64'd0);
    endtask

    // Observes handshakes until n responses complete; grants logged in order.
    task automatic run_stream(input int n);
        int             got;
        int             t;
        int             ch;
        logic [NCH-1:0] hs;
        logic [DW-1:0]  exp_d;
        got = 0;
        t   = 0;
        while (got < n && t < 400) begin
            @(negedge clk);
            t++;
            hs = req_valid & req_ready;
            if (hs != 0) grants.push_back(enc(hs));
            hs = resp_valid & resp_ready;
            if (hs != 0) begin
                ch    = enc(hs);
                exp_d = ~req_data[ch*DW +: DW];
                check("stream_resp_onehot", 64'($countones(resp_valid)), 64'd1);
                check("stream_resp_data", 64'(resp_data[ch*DW +: DW]), 64'(exp_d));
                got++;
            end
        end
        check("stream_count", 64'(got), 64'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  t;
        int  exp_order[6];
        bit  bad;

        vecs[0] = '{ch: 2, din: 16'h1234, exp: 16'hEDCB};
        vecs[1] = '{ch: 0, din: 16'h0000, exp: 16'hFFFF};
        vecs[2] = '{ch: 3, din: 16'hFFFF, exp: 16'h0000};
        vecs[3] = '{ch: 1, din: 16'hA5A5, exp: 16'h5A5A};
        vecs[4] = '{ch: 3, din: 16'h8001, exp: 16'h7FFE};
        exp_order = '{0, 1, 3, 0, 1, 3};

        // ---- reset state, with requests present during reset ----
        reset      = 1'b1;
        enable     = 1'b1;
        req_valid  = 4'hF;
        req_data   = 64'h4444_3333_2222_1111;
        resp_ready = 4'hF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_data", resp_data, 64'd0);
        check("rst_core_if", {46'd0, core_din, core_din_valid, core_dout_ready}, 64'd0);
        check("rst_grant_ch", 64'(grant_ch), 64'd0);
        @(posedge clk); #1;
        req_valid = '0;
        reset     = 1'b0;
        @(negedge clk);
        check("idle_no_req_ready", 64'(req_ready), 64'd0);

        // ---- table-driven single transactions ----
        for (int i = 0; i < 5; i++) do_single(vecs[i].ch, vecs[i].din, vecs[i].exp);

        // ---- contention: ch0, ch1, ch3 continuously valid ----
        do_reset();
        grants.delete();
        req_data  = 64'h0003_0000_0002_0001;
        req_valid = 4'b1011;
        run_stream(6);
        req_valid = '0;
        check("contention_grant_count", 64'(grants.size()), 64'd6);
        for (int i = 0; i < 6; i++)
            check("contention_grant_order",
                  64'((i < grants.size()) ? grants[i] : -1), 64'(exp_order[i]));
        wait_idle();

        // ---- result backpressure on ch1 while ch0 waits ----
        do_reset();
        resp_ready = 4'b1101;
        req_data   = 64'h0000_0000_0002_0001;
        req_valid  = 4'b0010;
        t = 0;
        @(negedge clk);
        while (!req_ready[1] && t < 20) begin @(negedge clk); t++; end
        @(posedge clk); #1;
        req_valid = 4'b0001;
        wait_resp();
        check("bp_resp_valid", 64'(resp_valid), 64'b0010);
        check("bp_resp_data", 64'(resp_data[1*DW +: DW]), 64'hFFFD);
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (req_ready != 0 || core_din_valid || resp_valid != 4'b0010) bad = 1'b1;
            @(negedge clk);
        end
        check("bp_stall_hold", 64'(bad), 64'd0);
        resp_ready = 4'hF;
        @(negedge clk);
        check("bp_released", 64'(resp_valid), 64'd0);
        check("bp_next_req_ready", 64'(req_ready), 64'b0001);
        @(negedge clk);
        check("bp_next_grant_valid", 64'(core_din_valid), 64'd1);
        check("bp_next_grant_ch", 64'(grant_ch), 64'd0);
        check("bp_next_core_din", 64'(core_din), 64'h0001);
        req_valid = '0;
        wait_idle();

        // ---- core input backpressure ----
        core_rdy_ctl = 1'b0;
        @(posedge clk); #1;
        req_data  = 64'h0000_5555_0000_0000;
        req_valid = 4'b0100;
        t = 0;
        @(negedge clk);
        while (!req_ready[2] && t < 20) begin @(negedge clk); t++; end
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (core_din != 16'h5555 || !core_din_valid || !busy || core_dout_ready) bad = 1'b1;
            @(negedge clk);
        end
        check("core_bp_hold", 64'(bad), 64'd0);
        core_rdy_ctl = 1'b1;
        wait_resp();
        check("core_bp_resp_valid", 64'(resp_valid), 64'b0100);
        check("core_bp_resp_data", 64'(resp_data[2*DW +: DW]), 64'hAAAA);
        wait_idle();

        // ---- reset during WAIT, spurious core result, priority restart ----
        @(posedge clk); #1;
        req_data  = 64'h0000_1111_0000_0000;
        req_valid = 4'b0100;
        t = 0;
        @(negedge clk);
        while (!core_dout_ready && t < 20) begin @(negedge clk); t++; end
        req_valid = '0;
        check("midwait_reached", 64'(core_dout_ready), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("midwait_rst_busy", 64'(busy), 64'd0);
        check("midwait_rst_resp", {60'd0, resp_valid}, 64'd0);
        check("midwait_rst_data", resp_data, 64'd0);
        check("midwait_rst_core_if", {46'd0, core_din, core_din_valid, core_dout_ready}, 64'd0);
        check("midwait_rst_grant", 64'(grant_ch), 64'd0);
        @(posedge clk); #1;
        force_d  = 16'hBEEF;
        force_dv = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (resp_valid != 0 || busy || core_dout_ready) bad = 1'b1;
        end
        check("spurious_dout_ignored", 64'(bad), 64'd0);
        @(posedge clk); #1;
        force_dv  = 1'b0;
        grants.delete();
        req_data  = 64'h0F00_0000_0000_00F0;
        req_valid = 4'b1001;
        run_stream(2);
        req_valid = '0;
        check("restart_first_grant", 64'((grants.size() > 0) ? grants[0] : -1), 64'd0);
        check("restart_second_grant", 64'((grants.size() > 1) ? grants[1] : -1), 64'd3);
        wait_idle();

        // ---- enable low blocks all traffic ----
        @(posedge clk); #1;
        enable    = 1'b0;
        req_data  = 64'h0000_0000_0A0A_0000;
        req_valid = 4'b0010;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (req_ready != 0 || core_din_valid || busy) bad = 1'b1;
        end
        check("enable_low_blocked", 64'(bad), 64'd0);
        @(posedge clk); #1;
        enable = 1'b1;
        @(negedge clk);
        check("enable_high_req_ready", 64'(req_ready), 64'b0010);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        check("enable_grant_ch", 64'(grant_ch), 64'd1);
        check("enable_core_din", 64'(core_din), 64'h0A0A);
        wait_resp();
        check("enable_resp_data", 64'(resp_data[1*DW +: DW]), 64'hF5F5);
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sine_taylor_arbiter.md
Name: sine_taylor_arbiter

Overview:
Shares one sine_taylor core between G_NUM_CH independent requesters. Requesters use valid/ready streams.
- Round-robin arbitration picks one pending request and forwards its sample to the core.
- Holds the channel tag while the core computes, then routes the result back to the originating channel's response stream.
- Exactly one transaction is in flight at a time, matching the core's one-sample-at-a-time handshake.

Parameters:
G_DWIDTH, 16, sample width (matches core din/dout)
G_NUM_CH, 4, number of requester channels (2..16)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
enable  in  1  0 behaves exactly like reset
req_data  in  G_NUM_CH*G_DWIDTH  packed request samples, channel i at [i*G_DWIDTH +: G_DWIDTH]
req_valid  in  G_NUM_CH  per-channel request valid
req_ready  out  G_NUM_CH  per-channel request ready, at most one bit set
resp_data  out  G_NUM_CH*G_DWIDTH  packed results; only the granted channel's slice is meaningful
resp_valid  out  G_NUM_CH  per-channel result valid, at most one bit set
resp_ready  in  G_NUM_CH  per-channel result ready
core_din  out  G_DWIDTH  sample to core
core_din_valid  out  1  to core
core_din_ready  in  1  from core
core_dout  in  G_DWIDTH  core result
core_dout_valid  in  1  from core
core_dout_ready  out  1  to core
busy  out  1  transaction in flight (state != IDLE)
grant_ch  out  $clog2(G_NUM_CH)  tag of current/last granted channel

Behaviour:
- Reset (or enable=0):
  - state=IDLE; rr_ptr=G_NUM_CH-1 so channel 0 wins first.
  - req_ready=0, resp_valid=0, resp_data=0, core_din_valid=0, core_din=0, core_dout_ready=0, busy=0, grant_ch=0.
- Arbitration (combinational, IDLE only):
  - Scan from rr_ptr+1 upward with wrap to find the first set req_valid bit; that index is sel.
  - req_ready = onehot(sel) when state=IDLE and any req_valid is set, else 0.
  - req_ready may depend on req_valid. Requesters must not make req_valid depend on req_ready.
- IDLE: on req_valid[sel] & req_ready[sel]:
  - latch core_din <= req_data slice sel; grant_ch <= sel;
  - core_din_valid <= 1; state <= ISSUE.
- ISSUE:
  - Hold core_din/core_din_valid until core_din_ready=1 in the same cycle as core_din_valid.
  - Then core_din_valid <= 0, core_dout_ready <= 1, state <= WAIT.
- WAIT: on core_dout_valid & core_dout_ready:
  - latch result into resp_data slice grant_ch; other slices hold 0.
  - core_dout_ready <= 0; resp_valid[grant_ch] <= 1; state <= DELIVER.
- DELIVER: on resp_ready[grant_ch] & resp_valid[grant_ch]:
  - resp_valid <= 0; rr_ptr <= grant_ch; state <= IDLE.
  - The next grant can be accepted in the following cycle.
- Minimum latency, req accept to resp_valid: 2 cycles plus core latency (ISSUE 1 cycle if core ready, WAIT for core result).
- Boundary conditions:
  - A req_valid that deasserts before acceptance is simply skipped.
  - All req_valid=0: stay IDLE, req_ready=0.
  - resp_ready held low stalls DELIVER indefinitely. No new grants; req_ready=0 throughout.
  - resp_ready asserted on a non-granted channel is ignored.
  - core_dout_valid outside WAIT is ignored; core_dout_ready=0 there.
  - Reset/enable drop mid-transaction: the transaction is discarded, no resp_valid. The core shares the same reset so it also aborts.
  - A single requester continuously valid is granted back-to-back.
  - With all requesters valid, each channel is granted once per G_NUM_CH transactions, so there is no starvation.

Decomposition:
- Package sine_taylor_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, DELIVER);
  - a function rr_select(valid vector, pointer) returning the winning index;
  - a default-width localparam.
- One natural sub-module: rr_arbiter (combinational round-robin select plus registered pointer update on grant_done), reusable elsewhere.
- The top module holds the FSM and data/tag registers.

Test Plan:
All scenarios use G_NUM_CH=4 and G_DWIDTH=16. The core model returns ~din, 5 cycles after accept.
- Single request: ch2 req_data=0x1234 valid → core_din=0x1234 with core_din_valid; resp_valid=4'b0100 with slice2=0xEDCB; grant_ch=2; other slices 0.
- Contention: ch0, ch1, ch3 all valid continuously with data 0x0001/0x0002/0x0003 → grant order 0,1,3,0,1,3; resp_valid one-hot, matching the order.
- Result backpressure: hold resp_ready[1]=0 for 10 cycles after resp_valid[1] while ch0 is valid → req_ready stays 0 and core_din_valid stays 0 for those 10 cycles. ch0 is granted 1 cycle after the resp handshake.
- Core backpressure: core_din_ready=0 for 6 cycles → core_din stable, core_din_valid held high, state ISSUE, busy=1.
- Reset mid-WAIT: assert reset for 1 cycle during WAIT → next cycle all outputs 0, busy=0. The subsequent core_dout_valid is ignored. A new ch3 request completes normally, with ch0 first in priority.
- Enable low: enable=0 with ch1 valid → req_ready=0 and no core traffic. Raising enable grants ch1 on the first IDLE cycle.
